featuremap_layer_scheduler: RTL
===============================

# featuremap_layer_scheduler

Sequences one convolution layer built from parallel per-filter featuremap blocks. It accepts an unpadded RGB image stream and inserts a one-pixel zero border. It broadcasts the padded frame into the shared input FIFOs of all filter blocks, then counts each filter's `valid_out` pulses until every filter has produced a full output map. It sits between the image source (line loader or previous-layer buffer) and the `NUM_FILTERS` featuremap instances.

## Interface
- `DATA_WIDTH`, default 32: bits per colour channel (IEEE-754 single).
- `WIDTH`, default 32: image width and height, square. The padded frame is (WIDTH+2)×(WIDTH+2).
- `NUM_FILTERS`, default 8: number of featuremap blocks driven.
- `DEPTH`, default 4096: featuremap FIFO depth. (WIDTH+2)² ≤ DEPTH is required, so no full check is made.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `start`  in  1  starts a frame; sampled only in IDLE.
- `pix_in`  in  3*DATA_WIDTH  input pixel, packed {B,G,R}.
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_ready`  out  1  the scheduler accepts `pix_in` this cycle.
- `fifo_data`  out  3*DATA_WIDTH  broadcast word to all featuremap `data_in` ports.
- `fifo_wren`  out  1  broadcast write enable.
- `fmap_valid`  in  NUM_FILTERS  `valid_out` of each featuremap block; bit i belongs to filter i.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse when a frame completes.
- `overrun`  out  1  sticky error flag.

## Operation
- States: IDLE, STREAM, WAIT, DONE.
- **IDLE**
  - If `start`=1: go to STREAM, clear `row`/`col` (each 0..WIDTH+1), clear all per-filter output counters, clear `overrun`.
- **STREAM**: walks the padded frame in raster order, `col` fastest.
  - Pad position: `row`∈{0, WIDTH+1} or `col`∈{0, WIDTH+1}.
    - Write an all-zero word unconditionally.
    - Advance the position every cycle.
    - `pix_ready`=0.
  - Interior position:
    - `pix_ready`=1.
    - On `pix_valid`&&`pix_ready`: write `pix_in` and advance.
    - Otherwise hold the position with no write.
  - After the write at (WIDTH+1, WIDTH+1): go to WAIT.
- **Per-filter output counters**
  - NUM_FILTERS counters, each $clog2(WIDTH*WIDTH+1) bits wide.
  - Active in STREAM and WAIT.
  - Counter i increments on `fmap_valid[i]` and saturates at WIDTH*WIDTH.
  - A pulse arriving at a saturated counter sets `overrun`.
  - `fmap_valid` is ignored in IDLE and DONE.
- **WAIT**
  - Go to DONE when every counter equals WIDTH*WIDTH.
  - This completion check is also evaluated in STREAM, but the exit from STREAM is always to WAIT.
- **DONE**: lasts one cycle, then returns to IDLE.
- `start` outside IDLE is ignored.
- `pix_in` is ignored whenever `pix_ready`=0.
- **Outputs**
  - `busy` = STREAM or WAIT.
  - `done` = DONE.
  - `overrun` holds until the next accepted `start` or reset.
- **Reset**
  - `rst` low in any state forces IDLE and zeroes all counters.
  - All outputs go to 0.
  - A partial frame is abandoned. The featuremap FIFOs are not flushed by this block; they share the same reset.

## Timing
- `fifo_data` and `fifo_wren` are registered: a write decided in cycle n appears at the outputs in cycle n+1 for exactly one cycle.
- `pix_ready` is decoded from registered state and counters only, with no combinational path from `pix_valid`.
- The `start` edge moves to STREAM. The first zero-pad write is visible on `fifo_wren` one cycle after the first STREAM cycle.
- With `pix_valid` held high, STREAM lasts exactly (WIDTH+2)² cycles and produces (WIDTH+2)² writes, of which WIDTH² carry pixels.
- Each cycle with `pix_valid`=0 at an interior position adds one cycle.
- The `fmap_valid` that completes the last counter moves the state from WAIT to DONE at the next edge. `done` is high for that one DONE cycle, and `busy` drops in the same cycle.
- The earliest next `start` is sampled in the IDLE cycle following DONE.
- Reset values: `pix_ready`=0, `fifo_wren`=0, `fifo_data`=0, `busy`=0, `done`=0, `overrun`=0.

## Test plan
- **Nominal frame**
  - Setup: WIDTH=4, `pix_valid` held high, pixels 1..16.
  - Writes: exactly 36, with zeros at the 20 border positions and pixels 1..16 in order at the interior.
  - STREAM lasts 36 cycles.
- **Stalled source**
  - Stimulus: `pix_valid` toggling 1/0.
  - Required: the same 36-word sequence, with no write or advance on stall cycles. A pad position never waits on `pix_valid`.
- **Completion**
  - Stimulus: 16 `fmap_valid` pulses per filter, the filters staggered.
  - Required: `done` high for exactly one cycle, one cycle after the last filter's 16th pulse. `busy` low in that cycle. `overrun`=0.
- **Overrun**
  - Stimulus: a 17th pulse on filter 3 while STREAM/WAIT still holds.
  - Required: `overrun`=1, filter 3's counter stays at 16, and `overrun` stays set until the next `start`.
- **Reset mid-frame**
  - Stimulus: `rst` low at padded position (2,3).
  - Required: all outputs 0 immediately (asynchronous). A subsequent `start` restarts from (0,0).
- **Start while busy**
  - Stimulus: `start` pulses during STREAM and during WAIT.
  - Required: no effect on counters, stream order or `done` timing.

Source files
------------

// File: rtl/featuremap_layer_scheduler.sv
// featuremap_layer_scheduler: adds a zero border to a frame, broadcasts it to the filter FIFOs, and tracks when every filter has finished
module featuremap_layer_scheduler #(
  parameter int DATA_WIDTH  = 32,
  parameter int WIDTH       = 32,
  parameter int NUM_FILTERS = 8,
  parameter int DEPTH       = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3*DATA_WIDTH-1:0] pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic [3*DATA_WIDTH-1:0] fifo_data,
  output logic                    fifo_wren,
  input  logic [NUM_FILTERS-1:0]  fmap_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);
  localparam int RW = $clog2(WIDTH + 2);
  localparam int CW = $clog2(WIDTH * WIDTH + 1);
  localparam logic [RW-1:0] LAST = RW'(WIDTH + 1);
  localparam logic [CW-1:0] MAX = CW'(WIDTH * WIDTH);

  if ((WIDTH + 2) * (WIDTH + 2) > DEPTH) begin : g_depth
    $error("featuremap FIFO depth too small for the padded frame");
  end

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, DONE} state_t;

  state_t state, state_nxt;
  logic [RW-1:0] row, col;
  logic [CW-1:0] cnt [NUM_FILTERS];
  logic [CW-1:0] cnt_nxt [NUM_FILTERS];
  logic pad, adv, last_col, last, active, all_full, hit_sat;

  assign pad       = row == '0 || row == LAST || col == '0 || col == LAST;
  assign last_col  = col == LAST;
  assign last      = last_col && row == LAST;
  assign active    = state == STREAM || state == WAIT;
  assign pix_ready = state == STREAM && !pad;
  assign adv       = state == STREAM && (pad || pix_valid);
  assign busy      = active;
  assign done      = state == DONE;

  // Per-filter saturating counters; completion looks at the post-update counts so the final pulse finishes the frame at the next edge
  always_comb begin
    all_full = 1'b1;
    hit_sat  = 1'b0;
    for (int i = 0; i < NUM_FILTERS; i++) begin
      cnt_nxt[i] = (active && fmap_valid[i] && cnt[i] != MAX) ? cnt[i] + 1'b1 : cnt[i];
      hit_sat    = hit_sat | (active && fmap_valid[i] && cnt[i] == MAX);
      all_full   = all_full & (cnt_nxt[i] == MAX);
    end
  end

  // Next state: STREAM always drains through WAIT, even if every filter is already complete
  always_comb begin
    state_nxt = (state == IDLE && start)       ? STREAM :
                (state == STREAM && adv && last) ? WAIT :
                (state == WAIT && all_full)     ? DONE :
                (state == DONE)                 ? IDLE : state;
  end

  // State, raster position, counters, sticky overrun and the registered FIFO write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      cnt       <= '{default: '0};
      overrun   <= 1'b0;
      fifo_wren <= 1'b0;
      fifo_data <= '0;
    end else begin
      state     <= state_nxt;
      fifo_wren <= adv;
      fifo_data <= (adv && !pad) ? pix_in : '0;
      if (state == IDLE && start) begin
        row     <= '0;
        col     <= '0;
        cnt     <= '{default: '0};
        overrun <= 1'b0;
      end else begin
        if (adv) begin
          col <= last_col ? '0 : col + 1'b1;
          row <= last_col ? row + 1'b1 : row;
        end
        cnt     <= cnt_nxt;
        overrun <= overrun | hit_sat;
      end
    end
  end
endmodule
